// File: rtl/rib_rr_arbiter.sv
// rtl/rib_rr_arbiter.sv - round-robin, transaction-locked RIB bus arbiter with watchdog
//
// Purpose:
//   Picks one of MASTER_NUM requesting masters in round-robin order and holds
//   the grant from that master's request handshake through its response
//   handshake. A watchdog drops the grant if the slave stalls in either phase.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   req_vld_i    per-master request valid
//   req_rdy_i    request ready of the granted transfer
//   rsp_vld_i    response valid of the granted transfer
//   rsp_rdy_i    response ready of the granted master
//   grant_o      one-hot grant, zero when idle (registered)
//   grant_idx_o  binary index of the granted master, holds last value when idle
//   busy_o       high while a transfer is in progress
//   timeout_o    single-cycle pulse when the watchdog fires
//   to_idx_o     index of the master that last timed out (sticky)
module rib_rr_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int IDX_W      = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req_vld_i,
  input  logic                  req_rdy_i,
  input  logic                  rsp_vld_i,
  input  logic                  rsp_rdy_i,
  output logic [MASTER_NUM-1:0] grant_o,
  output logic [IDX_W-1:0]      grant_idx_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [IDX_W-1:0]      to_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  localparam int              WD_W    = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [MASTER_NUM-1:0] ONE = {{(MASTER_NUM-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  timeout_q, timeout_d;
  logic [IDX_W-1:0]      to_idx_q, to_idx_d;

  logic [IDX_W-1:0]      arb_ptr;
  logic [IDX_W-1:0]      arb_cur;

  // First requester strictly after p, wrapping; p itself is checked last so a
  // lone master can win again.
  function automatic logic [IDX_W-1:0] arb(input logic [IDX_W-1:0]      p,
                                           input logic [MASTER_NUM-1:0] r);
    logic [IDX_W-1:0] res;
    logic             found;
    int               k;
    res   = p;
    found = 1'b0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      k = (int'(p) + i) % MASTER_NUM;
      if (!found && r[k]) begin
        res   = IDX_W'(k);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign arb_ptr = arb(ptr_q, req_vld_i);
  assign arb_cur = arb(gidx_q, req_vld_i);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    to_idx_d  = to_idx_q;

    case (state_q)
      S_IDLE: begin
        if (|req_vld_i) begin
          gidx_d  = arb_ptr;
          ptr_d   = arb_ptr;
          grant_d = ONE << arb_ptr;
          wdog_d  = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (req_vld_i[gidx_q] && req_rdy_i) begin
          wdog_d  = '0;
          state_d = S_RSP;
        end else if (!req_vld_i[gidx_q]) begin
          grant_d = '0;
          wdog_d  = '0;
          state_d = S_IDLE;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          to_idx_d  = gidx_q;
          grant_d   = '0;
          wdog_d    = '0;
          state_d   = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_RSP: begin
        // Completion wins over the watchdog when both happen on the same edge.
        if (rsp_vld_i && rsp_rdy_i) begin
          wdog_d = '0;
          if (|req_vld_i) begin
            // Zero-bubble regrant straight from the response phase.
            gidx_d  = arb_cur;
            ptr_d   = arb_cur;
            grant_d = ONE << arb_cur;
            state_d = S_REQ;
          end else begin
            grant_d = '0;
            state_d = S_IDLE;
          end
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          to_idx_d  = gidx_q;
          grant_d   = '0;
          wdog_d    = '0;
          state_d   = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: begin
        grant_d = '0;
        wdog_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= IDX_W'(MASTER_NUM - 1);
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      to_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      to_idx_q  <= to_idx_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = gidx_q;
  assign busy_o      = (state_q != S_IDLE);
  assign timeout_o   = timeout_q;
  assign to_idx_o    = to_idx_q;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb/tb_rib_rr_arbiter.sv - self-checking bench for rib_rr_arbiter
module tb_rib_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vld_i;
  logic       req_rdy_i;
  logic       rsp_vld_i;
  logic       rsp_rdy_i;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       busy_o;
  logic       timeout_o;
  logic [1:0] to_idx_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] e;

  always #5 clk = ~clk;

  rib_rr_arbiter #(
    .MASTER_NUM(4),
    .IDX_W     (2),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld_i  (req_vld_i),
    .req_rdy_i  (req_rdy_i),
    .rsp_vld_i  (rsp_vld_i),
    .rsp_rdy_i  (rsp_rdy_i),
    .grant_o    (grant_o),
    .grant_idx_o(grant_idx_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .to_idx_o   (to_idx_o)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] pop_exp();
    if (exp_q.size() == 0) return 4'bxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset;
    rst = 1'b1; req_vld_i = 4'b1111; req_rdy_i = 0; rsp_vld_i = 0; rsp_rdy_i = 0;
    tick(); tick();
    n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
    n_checks++; if (grant_idx_o !== 2'd0) begin n_fail++; $display("FAIL reset_gidx got=%0d exp=0", grant_idx_o); end
    n_checks++; if (to_idx_o !== 2'd0) begin n_fail++; $display("FAIL reset_to_idx got=%0d exp=0", to_idx_o); end
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    tick();
    e = pop_exp();
    n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=%b", grant_o, e); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got=%b exp=1", busy_o); end
    req_vld_i = 4'b0000;
    tick();
    n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL reset_withdraw got=%b exp=0000", grant_o); end
  endtask

  task automatic test_rotation;
    rst = 1'b1; req_vld_i = 4'b1111;
    tick();
    rst = 1'b0; req_rdy_i = 1; rsp_vld_i = 1; rsp_rdy_i = 1;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      e = pop_exp();
      n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL rot_grant[%0d] got=%b exp=%b", k, grant_o, e); end
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rot_bubble_req[%0d] busy=%b exp=1", k, busy_o); end
      tick();
      n_checks++; if (grant_o !== e || busy_o !== 1'b1) begin n_fail++; $display("FAIL rot_hold_rsp[%0d] got=%b busy=%b exp=%b busy=1", k, grant_o, busy_o, e); end
      tick();
    end
    req_vld_i = 4'b0000; req_rdy_i = 0; rsp_vld_i = 0;
    tick();
    n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL rot_end got=%b exp=0000", grant_o); end
  endtask

  task automatic test_lone_master;
    req_vld_i = 4'b0100; req_rdy_i = 1; rsp_vld_i = 1; rsp_rdy_i = 1;
    for (int k = 0; k < 3; k++) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    tick();
    for (int k = 0; k < 3; k++) begin
      e = pop_exp();
      n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL lone_grant[%0d] got=%b exp=%b", k, grant_o, e); end
      tick();
      if (k == 2) req_vld_i = 4'b0101;
      tick();
    end
    e = pop_exp();
    n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL lone_then_m0 got=%b exp=%b", grant_o, e); end
    req_vld_i = 4'b0000; req_rdy_i = 0; rsp_vld_i = 0;
    tick();
  endtask

  task automatic test_withdrawal;
    req_vld_i = 4'b0010; req_rdy_i = 0; rsp_vld_i = 0; rsp_rdy_i = 0;
    exp_q.push_back(4'b0010);
    tick();
    e = pop_exp();
    n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL wd_grant got=%b exp=%b", grant_o, e); end
    req_vld_i = 4'b0000;
    tick();
    n_checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL wd_release got=%b busy=%b exp=0000 busy=0", grant_o, busy_o); end
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL wd_no_timeout got=%b exp=0", timeout_o); end
    tick();
    n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL wd_no_timeout2 got=%b exp=0", timeout_o); end
  endtask

  task automatic test_timeout;
    req_vld_i = 4'b1000; req_rdy_i = 1; rsp_vld_i = 0; rsp_rdy_i = 1;
    exp_q.push_back(4'b1000);
    tick();
    e = pop_exp();
    n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL to_grant got=%b exp=%b", grant_o, e); end
    tick();
    req_vld_i = 4'b0000; req_rdy_i = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++; if (timeout_o !== 1'b0 || grant_o !== 4'b1000) begin n_fail++; $display("FAIL to_early[%0d] timeout=%b grant=%b exp timeout=0 grant=1000", i, timeout_o, grant_o); end
    end
    tick();
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_pulse got=%b exp=1", timeout_o); end
    n_checks++; if (to_idx_o !== 2'd3) begin n_fail++; $display("FAIL to_idx got=%0d exp=3", to_idx_o); end
    n_checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL to_release got=%b busy=%b exp=0000 busy=0", grant_o, busy_o); end
    tick();
    n_checks++; if (timeout_o !== 1'b0 || to_idx_o !== 2'd3) begin n_fail++; $display("FAIL to_one_shot timeout=%b to_idx=%0d exp timeout=0 to_idx=3", timeout_o, to_idx_o); end
  endtask

  task automatic test_reset_mid_rsp;
    req_vld_i = 4'b0100; req_rdy_i = 1; rsp_vld_i = 0; rsp_rdy_i = 0;
    exp_q.push_back(4'b0100);
    tick();
    e = pop_exp();
    n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL rmid_grant got=%b exp=%b", grant_o, e); end
    tick();
    req_rdy_i = 0;
    n_checks++; if (busy_o !== 1'b1 || grant_o !== 4'b0100) begin n_fail++; $display("FAIL rmid_in_rsp busy=%b grant=%b exp busy=1 grant=0100", busy_o, grant_o); end
    rst = 1'b1; req_vld_i = 4'b1010;
    tick();
    n_checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_drop got=%b busy=%b exp=0000 busy=0", grant_o, busy_o); end
    n_checks++; if (to_idx_o !== 2'd0 || grant_idx_o !== 2'd0) begin n_fail++; $display("FAIL rmid_idx to_idx=%0d gidx=%0d exp 0 0", to_idx_o, grant_idx_o); end
    rst = 1'b0;
    exp_q.push_back(4'b0010);
    tick();
    e = pop_exp();
    n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL rmid_regrant got=%b exp=%b", grant_o, e); end
    req_vld_i = 4'b0000;
    tick();
  endtask

  task automatic test_complete_at_limit;
    req_vld_i = 4'b0001; req_rdy_i = 1; rsp_vld_i = 0; rsp_rdy_i = 0;
    exp_q.push_back(4'b0001);
    tick();
    e = pop_exp();
    n_checks++; if (grant_o !== e) begin n_fail++; $display("FAIL lim_grant got=%b exp=%b", grant_o, e); end
    tick();
    req_vld_i = 4'b0000; req_rdy_i = 0;
    for (int i = 0; i < 7; i++) tick();
    rsp_vld_i = 1; rsp_rdy_i = 1;
    tick();
    n_checks++; if (timeout_o !== 1'b0 || to_idx_o !== 2'd0) begin n_fail++; $display("FAIL lim_priority timeout=%b to_idx=%0d exp timeout=0 to_idx=0", timeout_o, to_idx_o); end
    n_checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL lim_done got=%b busy=%b exp=0000 busy=0", grant_o, busy_o); end
    rsp_vld_i = 0; rsp_rdy_i = 0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_vld_i = '0; req_rdy_i = 0; rsp_vld_i = 0; rsp_rdy_i = 0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_lone_master();
    test_withdrawal();
    test_timeout();
    test_reset_mid_rsp();
    test_complete_at_limit();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1);
  end

endmodule
